wrsw_pkt_gen: RTL and testbench

Synthesizable multi-channel Ethernet frame generator for switch-core bring-up and soak testing. It produces WR-fabric-style 16-bit frame streams with sequence-numbered sequential payloads, LFSR-randomised sizes and inter-frame gaps. Each frame carries a per-channel source/destination port encoding, so a downstream checker can match frames to RTU static rules. It sits in front of an endpoint fabric sink, or in the loopback path of a switch port.

---
 rtl/wrsw_pkt_gen_pkg.sv | 58 +++++
 rtl/wrsw_pkt_gen_rr_arb.sv | 29 ++
 rtl/wrsw_pkt_gen.sv | 208 ++++++++++++++++++++
 tb/tb_wrsw_pkt_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrsw_pkt_gen_pkg.sv
// wrsw_pkt_gen shared definitions: header words,
// LFSR helpers and the generator state encoding.
package wrsw_pkt_gen_pkg;

  localparam logic [15:0] HDR_MAC_HI = 16'hCAFE;
  localparam logic [15:0] HDR_MAC_MD = 16'hBABE;
  localparam logic [15:0] SRC_MAC_34 = 16'h0304;
  localparam logic [15:0] SRC_MAC_56 = 16'h0506;
  localparam logic [15:0] HDR_ETYPE  = 16'h88F7;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          HDR_WORDS  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_HDR,
    S_PAY,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    lfsr_next = {1'b0, s[15:1]}
              ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [15:0] bitrev16(
    input logic [15:0] s
  );
    for (int i = 0; i < 16; i++)
      bitrev16[i] = s[15-i];
  endfunction

  // Payload word k>=1 at frame index 7+k carries bytes 2k-2, 2k-1.
  function automatic logic [15:0] frame_word(
    input logic [15:0] idx,
    input logic [7:0]  chan,
    input logic [7:0]  dst,
    input logic [15:0] seq
  );
    logic [15:0] t;
    t = {idx[14:0], 1'b0} - 16'd16;
    case (idx)
      16'd0:   frame_word = {dst, 8'h50};
      16'd1:   frame_word = HDR_MAC_HI;
      16'd2:   frame_word = HDR_MAC_MD;
      16'd3:   frame_word = {chan, 8'h02};
      16'd4:   frame_word = SRC_MAC_34;
      16'd5:   frame_word = SRC_MAC_56;
      16'd6:   frame_word = HDR_ETYPE;
      16'd7:   frame_word = seq;
      default: frame_word = {t[7:0], t[7:0] + 8'd1};
    endcase
  endfunction

endpackage

// File: rtl/wrsw_pkt_gen_rr_arb.sv
// Combinational round-robin arbiter: grants the first
// requester strictly after the last served index.
module wrsw_pkt_gen_rr_arb #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic          gnt_valid,
  output logic [CW-1:0] gnt_idx
);

  int j;

  // Scan farthest first so the nearest requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(last) + i) % N;
      if (req[CW'(j)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(j);
      end
    end
  end

endmodule

// File: rtl/wrsw_pkt_gen.sv
// Multi-channel WR-fabric frame generator with LFSR
// sized frames and gaps, round-robin over channels.
module wrsw_pkt_gen
  import wrsw_pkt_gen_pkg::*;
#(
  parameter int          g_num_channels = 4,
  parameter int          g_max_words    = 1024,
  parameter int          g_gap_width    = 16,
  parameter logic [15:0] g_seed         = 16'hACE1,
  localparam int SW = $clog2(g_max_words + 1),
  localparam int GW = g_gap_width,
  localparam int NC = g_num_channels
) (
  input  logic            clk_sys_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            enable_i,
  input  logic [NC-1:0]   chan_mask_i,
  input  logic [8*NC-1:0] dst_map_i,
  input  logic [15:0]     n_frames_i,
  input  logic [SW-1:0]   size_min_i,
  input  logic [SW-1:0]   size_max_i,
  input  logic [GW-1:0]   gap_min_i,
  input  logic [GW-1:0]   gap_max_i,
  output logic [15:0]     src_dat_o,
  output logic            src_valid_o,
  output logic            src_sop_o,
  output logic            src_eop_o,
  input  logic            src_stall_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [31:0]     frames_sent_o
);

  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  state_t          state;
  logic [15:0]     lfsr;
  logic [CW-1:0]   last_gnt;
  logic [CW-1:0]   chan_r;
  logic [7:0]      dst_r;
  logic [SW-1:0]   size_r;
  logic [SW-1:0]   widx;
  logic [GW-1:0]   gap_r;
  logic [GW-1:0]   gap_cnt;
  logic [15:0]     seq [NC];

  logic [NC-1:0]   elig;
  logic            gnt_valid;
  logic [CW-1:0]   gnt_idx;

  logic [SW:0]     size_span;
  logic [SW+16:0]  size_prod;
  logic [SW-1:0]   size_pick;
  logic [GW:0]     gap_span;
  logic [GW+16:0]  gap_prod;
  logic [GW-1:0]   gap_pick;

  logic            picking;
  logic [SW-1:0]   nxt_idx;
  logic [CW-1:0]   nxt_chan;
  logic [7:0]      nxt_dst;
  logic [SW-1:0]   nxt_size;
  logic [15:0]     nxt_word;
  logic            nxt_eop;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NC; c++)
      elig[c] = chan_mask_i[c]
              && (seq[c] < n_frames_i);
  end

  wrsw_pkt_gen_rr_arb #(
    .N  (NC),
    .CW (CW)
  ) u_arb (
    .req       (elig),
    .last      (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Scale the LFSR into [min, max] by multiply-shift.
  always_comb begin
    size_span = {1'b0, size_max_i}
              - {1'b0, size_min_i} + (SW+1)'(1);
    size_prod = {{(SW+1){1'b0}}, lfsr}
              * {16'b0, size_span};
    size_pick = (size_min_i > size_max_i)
              ? size_min_i
              : size_min_i + size_prod[SW+15:16];
    gap_span  = {1'b0, gap_max_i}
              - {1'b0, gap_min_i} + (GW+1)'(1);
    gap_prod  = {{(GW+1){1'b0}}, bitrev16(lfsr)}
              * {16'b0, gap_span};
    gap_pick  = (gap_min_i > gap_max_i)
              ? gap_min_i
              : gap_min_i + gap_prod[GW+15:16];
  end

  always_comb begin
    picking  = (state == S_PICK);
    nxt_idx  = picking ? '0 : widx + SW'(1);
    nxt_chan = picking ? gnt_idx : chan_r;
    nxt_dst  = picking
             ? dst_map_i[8*int'(gnt_idx) +: 8]
             : dst_r;
    nxt_size = picking ? size_pick : size_r;
    nxt_word = frame_word(16'(nxt_idx),
                          8'(nxt_chan),
                          nxt_dst,
                          seq[nxt_chan]);
    nxt_eop  = (nxt_idx == nxt_size - SW'(1));
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      lfsr          <= g_seed;
      last_gnt      <= CW'(NC - 1);
      chan_r        <= '0;
      dst_r         <= '0;
      size_r        <= '0;
      widx          <= '0;
      gap_r         <= '0;
      gap_cnt       <= '0;
      for (int c = 0; c < NC; c++)
        seq[c] <= '0;
      src_dat_o     <= '0;
      src_valid_o   <= 1'b0;
      src_sop_o     <= 1'b0;
      src_eop_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      frames_sent_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            frames_sent_o <= '0;
            last_gnt      <= CW'(NC - 1);
            for (int c = 0; c < NC; c++)
              seq[c] <= '0;
            if (enable_i && |chan_mask_i
                && n_frames_i != 16'd0) begin
              state  <= S_PICK;
              busy_o <= 1'b1;
              done_o <= 1'b0;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        S_PICK: begin
          lfsr <= lfsr_next(lfsr);
          if (!enable_i || !gnt_valid) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state       <= S_HDR;
            chan_r      <= gnt_idx;
            last_gnt    <= gnt_idx;
            dst_r       <= nxt_dst;
            size_r      <= size_pick;
            gap_r       <= gap_pick;
            widx        <= '0;
            src_dat_o   <= nxt_word;
            src_valid_o <= 1'b1;
            src_sop_o   <= 1'b1;
            src_eop_o   <= nxt_eop;
          end
        end
        S_HDR, S_PAY: begin
          if (!src_stall_i) begin
            if (src_eop_o) begin
              src_valid_o <= 1'b0;
              src_sop_o   <= 1'b0;
              src_eop_o   <= 1'b0;
              seq[chan_r] <= seq[chan_r] + 16'd1;
              if (frames_sent_o != '1)
                frames_sent_o <= frames_sent_o + 32'd1;
              gap_cnt <= gap_r;
              state   <= (gap_r == '0) ? S_PICK : S_GAP;
            end else begin
              widx      <= nxt_idx;
              src_dat_o <= nxt_word;
              src_sop_o <= 1'b0;
              src_eop_o <= nxt_eop;
              state     <= (nxt_idx < SW'(HDR_WORDS))
                         ? S_HDR : S_PAY;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1))
            state <= S_PICK;
          else
            gap_cnt <= gap_cnt - GW'(1);
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrsw_pkt_gen.sv
// Self-checking bench for wrsw_pkt_gen: frame-level
// reference model plus directed literal expectations.
module tb_wrsw_pkt_gen;

  localparam int NCH = 4;
  localparam int SW  = 11;
  localparam int GW  = 16;

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          enable  = 1'b0;
  logic          stall   = 1'b0;
  logic [3:0]    mask    = '0;
  logic [31:0]   dst_map = '0;
  logic [15:0]   n_frames = '0;
  logic [SW-1:0] smin = 11'd8, smax = 11'd8;
  logic [GW-1:0] gmin = '0, gmax = '0;
  logic [15:0]   dat;
  logic          valid, sop, eop, busy, done;
  logic [31:0]   frames_sent;

  int checks   = 0;
  int failures = 0;
  int stall_pct = 0;

  always #5 clk_sys = ~clk_sys;

  wrsw_pkt_gen dut (
    .clk_sys_i     (clk_sys),
    .rst_n_i       (rst_n),
    .start_i       (start),
    .enable_i      (enable),
    .chan_mask_i   (mask),
    .dst_map_i     (dst_map),
    .n_frames_i    (n_frames),
    .size_min_i    (smin),
    .size_max_i    (smax),
    .gap_min_i     (gmin),
    .gap_max_i     (gmax),
    .src_dat_o     (dat),
    .src_valid_o   (valid),
    .src_sop_o     (sop),
    .src_eop_o     (eop),
    .src_stall_i   (stall),
    .busy_o        (busy),
    .done_o        (done),
    .frames_sent_o (frames_sent)
  );

  // Reference frame list
  int exp_chan[$], exp_size[$], exp_gap[$], exp_seq[$];
  int exp_n;

  // Monitor state and observations
  int   m_fi, m_wi, m_idle;
  bit   m_in, m_en, m_prev_vs;
  logic [15:0] p_dat;
  logic p_sop, p_eop;
  int obs_size[$], obs_idle[$], obs_chan[$];
  int obs_seq[$], obs_w19[$], obs_w0[$];

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    if (s[0]) return (s >> 1) ^ 16'hB400;
    return s >> 1;
  endfunction

  function automatic logic [15:0] rev16(logic [15:0] s);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = s[15-i];
    return r;
  endfunction

  function automatic logic [15:0] model_word(
      int ch, logic [7:0] d, int sq, int idx);
    int k;
    case (idx)
      0: return {d, 8'h50};
      1: return 16'hCAFE;
      2: return 16'hBABE;
      3: return {8'(ch), 8'h02};
      4: return 16'h0304;
      5: return 16'h0506;
      6: return 16'h88F7;
      7: return 16'(sq);
      default: begin
        k = idx - 7;
        return {8'(2*k-2), 8'(2*k-1)};
      end
    endcase
  endfunction

  // Frame list from the rules: RR order, multiply-shift sizes.
  task automatic build_model();
    int cnt[NCH];
    int last, g, c, sz, gp, span;
    logic [15:0] s;
    exp_chan.delete(); exp_size.delete();
    exp_gap.delete();  exp_seq.delete();
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    last = NCH - 1;
    s = 16'hACE1;
    forever begin
      g = -1;
      for (int i = 1; i <= NCH; i++) begin
        c = (last + i) % NCH;
        if (g < 0 && mask[c] && cnt[c] < int'(n_frames)) g = c;
      end
      if (g < 0) break;
      if (smin > smax) sz = int'(smin);
      else begin
        span = int'(smax) - int'(smin) + 1;
        sz = int'(smin) + int'((longint'(s) * span) >>> 16);
      end
      if (gmin > gmax) gp = int'(gmin);
      else begin
        span = int'(gmax) - int'(gmin) + 1;
        gp = int'(gmin)
           + int'((longint'(rev16(s)) * span) >>> 16);
      end
      exp_chan.push_back(g);
      exp_size.push_back(sz);
      exp_gap.push_back(gp);
      exp_seq.push_back(cnt[g]);
      cnt[g]++;
      last = g;
      s = lfsr_step(s);
    end
    exp_n = exp_chan.size();
  endtask

  task automatic mon_clear();
    m_fi = 0; m_wi = 0; m_idle = 0;
    m_in = 0; m_prev_vs = 0;
    obs_size.delete(); obs_idle.delete(); obs_chan.delete();
    obs_seq.delete();  obs_w19.delete();  obs_w0.delete();
  endtask

  task automatic monitor_loop();
    logic [15:0] ew;
    int ch, sz;
    forever begin
      @(negedge clk_sys);
      if (m_en && rst_n) begin
        if (m_prev_vs)
          chk(valid && dat == p_dat && sop == p_sop
              && eop == p_eop, "stall_hold", dat, p_dat);
        if (valid) begin
          if (!m_in) begin
            m_in = 1;
            if (m_fi > 0 && m_fi <= exp_n) begin
              chk(m_idle == exp_gap[m_fi-1] + 1, "gap_len",
                  m_idle, exp_gap[m_fi-1] + 1);
              obs_idle.push_back(m_idle);
            end
          end
          if (m_fi >= exp_n) begin
            chk(0, "extra_frame", m_fi, exp_n);
            m_en = 0;
          end else if (!stall) begin
            ch = exp_chan[m_fi];
            sz = exp_size[m_fi];
            ew = model_word(ch, dst_map[8*ch +: 8],
                            exp_seq[m_fi], m_wi);
            chk(dat == ew && sop == (m_wi == 0)
                && eop == (m_wi == sz - 1), "word",
                {eop, sop, dat}, {m_wi == sz - 1, m_wi == 0, ew});
            if (m_fi == 0) obs_w0.push_back(int'(dat));
            if (m_wi == 3) obs_chan.push_back(int'(dat[15:8]));
            if (m_wi == 7) obs_seq.push_back(int'(dat));
            if (m_wi == 19) obs_w19.push_back(int'(dat));
            if (eop) begin
              obs_size.push_back(m_wi + 1);
              m_fi++; m_wi = 0; m_in = 0; m_idle = 0;
            end else m_wi++;
          end
        end else begin
          if (m_in) begin
            chk(0, "valid_drop", m_wi, exp_size[m_fi]);
            m_in = 0;
          end
          m_idle++;
        end
        m_prev_vs = valid && stall;
        p_dat = dat; p_sop = sop; p_eop = eop;
      end else m_prev_vs = 0;
    end
  endtask

  task automatic stall_loop();
    forever begin
      @(posedge clk_sys);
      #1;
      stall = (stall_pct > 0)
           && (int'($urandom_range(99)) < stall_pct);
    end
  endtask

  task automatic do_reset();
    stall_pct = 0;
    m_en = 0;
    start = 0; enable = 0; rst_n = 0;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1;
    @(negedge clk_sys);
    chk(!valid && !sop && !eop && !busy && !done
        && frames_sent == 0 && dat == 0, "reset_state",
        {valid, busy, done, frames_sent}, 0);
  endtask

  task automatic run(input int limit, input int drop_fi,
                     input int budget);
    int k;
    enable = 1;
    build_model();
    if (limit >= 0 && limit < exp_n) exp_n = limit;
    mon_clear();
    m_en = 1;
    @(posedge clk_sys); #1 start = 1;
    @(posedge clk_sys); #1 start = 0;
    if (stall_pct == 0 && exp_n > 0) begin
      @(negedge clk_sys);
      chk(busy && !valid, "t1_pick", {busy, valid}, 2'b10);
      @(negedge clk_sys);
      chk(valid && sop, "t2_sop", {valid, sop}, 2'b11);
    end
    for (k = 0; k < budget; k++) begin
      @(negedge clk_sys);
      if (drop_fi >= 0 && m_fi == drop_fi && m_wi >= 4)
        enable = 0;
      if (done && !busy) break;
    end
    chk(k < budget, "run_timeout", k, budget);
    chk(m_fi == exp_n, "frame_count", m_fi, exp_n);
    chk(frames_sent == 32'(exp_n), "frames_sent",
        frames_sent, exp_n);
    chk(done && !busy && !valid, "done_state",
        {done, busy, valid}, 3'b100);
  endtask

  logic [15:0] fixed_words [8];
  int rr_order [6];
  int mn, mx, bad, k;

  initial begin
    fork
      monitor_loop();
      stall_loop();
    join_none
    fixed_words = '{16'h0150, 16'hCAFE, 16'hBABE, 16'h0002,
                    16'h0304, 16'h0506, 16'h88F7, 16'h0000};
    rr_order = '{0, 1, 3, 0, 1, 3};

    // Fixed frame
    do_reset();
    mask = 4'b0001; dst_map = 32'h0000_0001; n_frames = 1;
    smin = 8; smax = 8; gmin = 0; gmax = 0;
    run(-1, -1, 200);
    chk(obs_w0.size() == 8, "fixed_len", obs_w0.size(), 8);
    for (int i = 0; i < 8 && i < obs_w0.size(); i++)
      chk(obs_w0[i] == int'(fixed_words[i]), "fixed_word",
          obs_w0[i], fixed_words[i]);
    chk(frames_sent == 1, "fixed_sent", frames_sent, 1);

    // Random stall
    do_reset();
    mask = 4'b0001; dst_map = 32'h0000_00A5; n_frames = 3;
    smin = 20; smax = 20; gmin = 0; gmax = 5;
    stall_pct = 50;
    run(-1, -1, 2000);
    stall_pct = 0;
    chk(obs_w19.size() > 0 && obs_w19[0] == 16'h1617,
        "pay_word12", obs_w19.size() > 0 ? obs_w19[0] : -1,
        16'h1617);
    for (int i = 0; i < 3; i++)
      chk(obs_seq.size() == 3 && obs_seq[i] == i, "stall_seq",
          obs_seq.size() == 3 ? obs_seq[i] : -1, i);

    // Round robin
    do_reset();
    mask = 4'b1011; dst_map = 32'h4433_2211; n_frames = 2;
    smin = 8; smax = 12; gmin = 0; gmax = 3;
    run(-1, -1, 1000);
    for (int i = 0; i < 6; i++)
      chk(obs_chan.size() == 6 && obs_chan[i] == rr_order[i],
          "rr_order", obs_chan.size() == 6 ? obs_chan[i] : -1,
          rr_order[i]);
    chk(frames_sent == 6, "rr_sent", frames_sent, 6);

    // Random size and gap
    do_reset();
    mask = 4'b1111; dst_map = 32'h0403_0201; n_frames = 150;
    smin = 8; smax = 64; gmin = 3; gmax = 10;
    run(-1, -1, 60000);
    mn = 9999; mx = 0; bad = 0;
    foreach (obs_size[i]) begin
      if (obs_size[i] < mn) mn = obs_size[i];
      if (obs_size[i] > mx) mx = obs_size[i];
      if (obs_size[i] < 8 || obs_size[i] > 64) bad++;
    end
    chk(bad == 0, "size_bounds", bad, 0);
    chk(mn == 8, "size_min_hit", mn, 8);
    chk(mx == 64, "size_max_hit", mx, 64);
    bad = 0;
    foreach (obs_idle[i])
      if (obs_idle[i] < 4 || obs_idle[i] > 11) bad++;
    chk(bad == 0, "idle_bounds", bad, 0);
    chk(obs_size.size() > 0 && obs_size[0] == 46, "first_size",
        obs_size.size() > 0 ? obs_size[0] : -1, 46);
    chk(obs_idle.size() > 0 && obs_idle[0] == 8, "first_idle",
        obs_idle.size() > 0 ? obs_idle[0] : -1, 8);

    // Enable drop during frame 2
    do_reset();
    mask = 4'b0001; dst_map = 32'h0000_0007; n_frames = 5;
    smin = 16; smax = 16; gmin = 0; gmax = 0;
    run(2, 1, 500);
    chk(frames_sent == 2, "drop_sent", frames_sent, 2);

    // Reset mid-payload, then a zero-frame run
    do_reset();
    mask = 4'b0001; dst_map = 32'h0000_0003; n_frames = 3;
    smin = 20; smax = 20; gmin = 0; gmax = 0;
    enable = 1;
    build_model();
    mon_clear();
    m_en = 1;
    @(posedge clk_sys); #1 start = 1;
    @(posedge clk_sys); #1 start = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk_sys);
      if (m_wi >= 10) break;
    end
    chk(k < 100, "mid_wait", k, 100);
    m_en = 0;
    #2 rst_n = 0;
    #1 chk(!valid && !sop && !eop && !busy
           && frames_sent == 0, "async_rst",
           {valid, sop, eop, busy}, 0);
    @(posedge clk_sys); #1 rst_n = 1;
    n_frames = 0;
    run(-1, -1, 100);
    repeat (20) @(negedge clk_sys);
    chk(m_fi == 0 && !m_in && !valid, "zero_no_sop",
        {m_fi, m_in, valid}, 0);
    chk(done && !busy, "zero_done", {done, busy}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
